alu_pipe: RTL

//  Parametrised successor to the lab-2 combinational ALU. Adds SLT, signed overflow
//  (ex), a zero flag and an illegal-opcode flag. Two-stage registered pipeline with

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_core.sv | 54 +++++
 rtl/alu_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and legality check shared by the ALU core and pipeline.
// Purely declarative: no logic, no latency, no flow control.
package alu_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT);
    endfunction
endpackage

// File: rtl/alu_core.sv
// Combinational ALU with one shared adder (b inverted, carry-in = op[2]).
// Zero latency; has no handshake of its own, so the caller's registers provide backpressure.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_z,
    output logic             o_ex,
    output logic             o_bad_op
);
    logic             w_sub;
    logic [WIDTH-1:0] w_b_opnd;
    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_sum;
    logic             w_c_msb;
    logic             w_c_out;
    logic             w_msb;
    logic             w_ovf;
    logic             w_less;

    assign w_sub    = i_op[2];
    assign w_b_opnd = w_sub ? ~i_b : i_b;

    // Split the adder at the MSB so the carry into it is visible for overflow.
    assign w_low   = {1'b0, i_a[WIDTH-2:0]} + {1'b0, w_b_opnd[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, w_sub};
    assign w_c_msb = w_low[WIDTH-1];
    assign {w_c_out, w_msb} = {1'b0, i_a[WIDTH-1]} + {1'b0, w_b_opnd[WIDTH-1]}
                            + {1'b0, w_c_msb};
    assign w_sum   = {w_msb, w_low[WIDTH-2:0]};
    assign w_ovf   = w_c_msb ^ w_c_out;
    assign w_less  = w_msb ^ w_ovf;

    always_comb begin
        o_z      = '0;
        o_ex     = 1'b0;
        o_bad_op = !is_legal_op(i_op);
        case (i_op)
            ALU_AND: o_z = i_a & i_b;
            ALU_OR:  o_z = i_a | i_b;
            ALU_ADD,
            ALU_SUB: begin
                o_z  = w_sum;
                o_ex = w_ovf;
            end
            ALU_SLT: o_z = {{(WIDTH-1){1'b0}}, w_less};
            default: o_z = '0;
        endcase
    end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with saturating overflow counter; accept at edge N -> out_valid after N+1.
// Per-stage ready: S2 holds while out_ready=0, S1 fills behind it, then in_ready drops.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             ex,
    output logic             zero,
    output logic             bad_op,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ovf_cnt
);
    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_v;
    logic [WIDTH-1:0] r_z;
    logic             r_ex;
    logic             r_zero;
    logic             r_bad_op;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_rdy;
    logic [WIDTH-1:0] w_z;
    logic             w_ex;
    logic             w_bad_op;

    assign w_s2_rdy = !r_s2_v || out_ready;
    assign in_ready = !r_s1_v || w_s2_rdy;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_op     (r_s1_op),
        .o_z      (w_z),
        .o_ex     (w_ex),
        .o_bad_op (w_bad_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_op  <= '0;
            r_s1_tag <= '0;
        end else if (in_ready) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_a   <= a;
                r_s1_b   <= b;
                r_s1_op  <= op;
                r_s1_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_z      <= '0;
            r_ex     <= 1'b0;
            r_zero   <= 1'b0;
            r_bad_op <= 1'b0;
            r_tag    <= '0;
        end else if (w_s2_rdy) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_z      <= w_z;
                r_ex     <= w_ex;
                r_zero   <= (w_z == '0);
                r_bad_op <= w_bad_op;
                r_tag    <= r_s1_tag;
            end
        end
    end

    // Counts delivered overflowing results only, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_s2_v && out_ready && r_ex && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_v;
    assign z         = r_z;
    assign ex        = r_ex;
    assign zero      = r_zero;
    assign bad_op    = r_bad_op;
    assign out_tag   = r_tag;
    assign ovf_cnt   = r_cnt;
endmodule
